// File: rtl/spi_rx_controller.sv
// SPI receive-only slave: deserialises WIDTH-bit frames (MSB first) into a held message register.
// Latency: pins to shift register SYNC_STAGES+1 clk cycles; last sampled bit to msg_valid one more cycle.
// Backpressure: msg_valid/msg_ready handshake; a frame completing while msg is held and not accepted is dropped and flags overrun.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   sclk, cs_n, MOSI  SPI pins, asynchronous to clk, each synchronised internally
//   msg_ready         consumer accepts msg when msg_valid=1 and msg_ready=1
//   clr_err           one-cycle pulse clearing the sticky overrun flag
//   msg, msg_valid    last completed frame and its valid flag
//   leds              live view of the receive shift register
//   busy              a frame is in progress (RECV or WAIT_END)
//   frame_err         one-cycle pulse when cs_n rises part-way through a frame
//   overrun           sticky, a completed frame was dropped
module spi_rx_controller #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             MOSI,
    input  logic             msg_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] msg,
    output logic             msg_valid,
    output logic [WIDTH-1:0] leds,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        WAIT_END = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers: bit 0 takes the raw pin, the MSB is the safe copy.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
        end
    end

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // sclk rising-edge detect on the synchronised copy.
    // r_armed records that cs_n has been seen deasserted since reset, so a
    // chip select already low when reset is released cannot start a frame
    // in the middle of a transfer.
    // ------------------------------------------------------------------
    logic r_sclk_d;
    logic r_armed;
    logic w_sclk_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_d <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk_s;
            if (w_cs_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic               r_frame_done;
    logic               r_frame_err;
    logic               w_clear;
    logic               w_shift_en;
    logic               w_done;
    logic               w_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_shift_en   = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_armed && !w_cs_s) begin
                    w_next_state = RECV;
                    w_clear      = 1'b1;
                end
            end
            RECV: begin
                // Chip select release wins over a coincident sclk edge.
                if (w_cs_s) begin
                    w_next_state = IDLE;
                    w_err        = (r_bit_cnt != '0);
                end else if (w_sclk_rise) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
                        w_next_state = WAIT_END;
                        w_done       = 1'b1;
                    end
                end
            end
            WAIT_END: begin
                // Surplus sclk edges are ignored until cs_n is released.
                if (w_cs_s) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register and bit counter. A partial frame stays visible on leds
    // after an aborted transfer; it is only cleared when the next frame starts.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_clear) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            r_shift   <= {r_shift[WIDTH-2:0], w_mosi_s};
        end
    end

    // frame_done is registered so that it lines up with the shift register
    // already holding the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= w_done;
            r_frame_err  <= w_err;
        end
    end

    // ------------------------------------------------------------------
    // Message holding register with valid/ready handshake and overrun flag.
    // A frame arriving in the same cycle the held one is accepted simply
    // replaces it, keeping msg_valid high.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_msg;
    logic             r_msg_valid;
    logic             r_overrun;
    logic             w_drop;

    assign w_drop = r_frame_done & r_msg_valid & ~msg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg       <= '0;
            r_msg_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (r_frame_done) begin
                if (!r_msg_valid || msg_ready) begin
                    r_msg       <= r_shift;
                    r_msg_valid <= 1'b1;
                end
            end else if (r_msg_valid && msg_ready) begin
                r_msg_valid <= 1'b0;
            end

            // A new drop takes priority over a coincident clear.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign msg       = r_msg;
    assign msg_valid = r_msg_valid;
    assign leds      = r_shift;
    assign busy      = (r_state != IDLE);
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
